// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM,
// valid/ack handshake with frame error and overrun pulses.
module uart_rx #(
    parameter int DATA_W       = 10,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              rx,
    input  logic              data_ack,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              meta_q, meta_d;
    logic              rx_s_q, rx_s_d;
    logic              rx_prev_q, rx_prev_d;

    logic half_tick;
    logic full_tick;
    logic fall;
    logic bit_tick;
    logic stop_tick;
    logic done;

    assign half_tick = (cnt_q == HALF_M1);
    assign full_tick = (cnt_q == FULL_M1);
    assign fall      = rx_en & rx_prev_q & ~rx_s_q;
    assign bit_tick  = rx_en & full_tick & (state_q == S_DATA);
    assign stop_tick = rx_en & full_tick & (state_q == S_STOP);
    assign done      = stop_tick & rx_s_q;

    // Synchronizer chain and edge-detect history always run.
    always_comb begin
        meta_d    = rx;
        rx_s_d    = meta_q;
        rx_prev_d = rx_s_q;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            meta_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            meta_q      <= meta_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
        end
    end

    // Next state, bit-clock counter and bit index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (half_tick) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (full_tick) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (full_tick) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_BREAK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        if (!rx_en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    // Shift register, host word, handshake flags and pulses.
    always_comb begin
        shift_d = shift_q;
        if (bit_tick) begin
            shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
        end
        data_d      = done ? shift_q : data_q;
        valid_d     = done | (valid_q & ~data_ack);
        overrun_d   = done & valid_q & ~data_ack;
        frame_err_d = stop_tick & ~rx_s_q;
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames checked
// every cycle against a timestamp-based frame model.
module tb_uart_rx;

    localparam int DW  = 10;
    localparam int CPB = 16;
    localparam int LAT = CPB / 2 + (DW + 1) * CPB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_en = 1'b1;
    logic          rx = 1'b1;
    logic          data_ack = 1'b0;
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    uart_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en     (rx_en),
        .rx        (rx),
        .data_ack  (data_ack),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;
    int ack_mode = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Behavioural model: a frame is timed from the cycle its
    // start edge is seen; sample k is taken at 8+16k cycles.
    logic          m_s1 = 1, m_s2 = 1, m_prev = 1;
    int            m_mode = 0;
    int            m_t0 = 0;
    int            cyc = 0;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_valid = 0, m_fe = 0, m_ov = 0;
    bit            ev_done, ev_fe;
    int            off, k;

    always @(posedge clk) begin
        ev_done = 0;
        ev_fe   = 0;
        if (!rst) begin
            m_s1 = 1; m_s2 = 1; m_prev = 1;
            m_mode = 0;
            m_data = '0; m_valid = 0;
            m_fe = 0; m_ov = 0;
        end else begin
            if (!rx_en) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (m_prev && !m_s2) begin
                    m_mode = 1;
                    m_t0   = cyc;
                end
            end else if (m_mode == 1) begin
                off = cyc - m_t0;
                if (off >= CPB / 2 && (off - CPB / 2) % CPB == 0) begin
                    k = (off - CPB / 2) / CPB;
                    if (k == 0) begin
                        if (m_s2) m_mode = 0;
                    end else if (k <= DW) begin
                        m_word[k-1] = m_s2;
                    end else if (m_s2) begin
                        ev_done = 1;
                        m_mode  = 0;
                    end else begin
                        ev_fe  = 1;
                        m_mode = 2;
                    end
                end
            end else if (m_s2) begin
                m_mode = 0;
            end
            m_fe = ev_fe;
            m_ov = ev_done && m_valid && !data_ack;
            if (ev_done) begin
                m_data  = m_word;
                m_valid = 1;
            end else if (data_ack) begin
                m_valid = 0;
            end
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = rx;
        end
        cyc++;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("data", 32'(data), 32'(m_data));
            chk("valid", 32'(valid), 32'(m_valid));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
            chk("overrun", 32'(overrun), 32'(m_ov));
            chk("busy", 32'(busy), 32'(m_mode != 0));
        end
    end

    // Host side: never, always, or randomly acknowledge.
    always @(negedge clk) begin
        data_ack = 1'b0;
        if (ack_mode == 1 && valid === 1'b1)
            data_ack = 1'b1;
        else if (ack_mode == 2 && valid === 1'b1 &&
                 $urandom_range(0, 3) == 0)
            data_ack = 1'b1;
    end

    // Event counters observed from the DUT outputs.
    logic          v_prev = 1'b0;
    int            fe_cnt = 0, ov_cnt = 0, bz_cnt = 0;
    logic [DW-1:0] rise_q[$];
    int            fe0, ov0, bz0;
    int            fe_d, ov_d, bz_d, nrise;

    always @(negedge clk) begin
        if (valid === 1'b1 && v_prev !== 1'b1)
            rise_q.push_back(data);
        v_prev = valid;
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (busy === 1'b1) bz_cnt++;
    end

    task automatic snap();
        @(posedge clk);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        bz0 = bz_cnt;
        rise_q.delete();
        @(negedge clk);
    endtask

    task automatic grab();
        @(posedge clk);
        fe_d  = fe_cnt - fe0;
        ov_d  = ov_cnt - ov0;
        bz_d  = bz_cnt - bz0;
        nrise = rise_q.size();
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] w,
                              input logic stop,
                              input int nd);
        drive_bit(1'b0);
        for (int i = 0; i < nd; i++) drive_bit(w[i]);
        if (nd == DW) drive_bit(stop);
    endtask

    int            lat;
    logic [DW-1:0] rw;
    logic          rstop;

    initial begin
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_data", 32'(data), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ovr", 32'(overrun), 0);
        rst = 1'b1;
        idle(2);

        // Single frame with latency measured from rx
        snap();
        lat = 0;
        fork
            send_frame(10'h2A5, 1'b1, DW);
            begin
                while (valid !== 1'b1 && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        idle(2);
        grab();
        chk("t1_latency", lat, LAT + 2);
        chk("t1_data", 32'(data), 32'h2A5);
        chk("t1_valid", 32'(valid), 1);
        chk("t1_ferr", fe_d, 0);
        chk("t1_ovr", ov_d, 0);
        ack_mode = 1;
        idle(1);
        chk("t1_acked", 32'(valid), 0);

        // Two frames, each acknowledged
        snap();
        send_frame(10'h001, 1'b1, DW);
        idle(2);
        send_frame(10'h3FF, 1'b1, DW);
        idle(2);
        grab();
        chk("t2_rises", nrise, 2);
        if (nrise == 2) begin
            chk("t2_word0", 32'(rise_q[0]), 32'h001);
            chk("t2_word1", 32'(rise_q[1]), 32'h3FF);
        end
        chk("t2_ovr", ov_d, 0);

        // Two frames, no acknowledge: one overrun
        ack_mode = 0;
        snap();
        send_frame(10'h001, 1'b1, DW);
        idle(2);
        send_frame(10'h3FF, 1'b1, DW);
        idle(2);
        grab();
        chk("t3_data", 32'(data), 32'h3FF);
        chk("t3_valid", 32'(valid), 1);
        chk("t3_ovr", ov_d, 1);
        chk("t3_rises", nrise, 1);
        ack_mode = 1;
        idle(1);

        // Short glitch on an idle line
        snap();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(2);
        grab();
        chk("t4_busy_le8", 32'(bz_d >= 1 && bz_d <= 8), 1);
        chk("t4_rises", nrise, 0);
        chk("t4_ferr", fe_d, 0);

        // Framing error, line held low, then good frame
        ack_mode = 0;
        snap();
        send_frame(10'h155, 1'b0, DW);
        repeat (40) @(negedge clk);
        idle(2);
        grab();
        chk("t5_ferr", fe_d, 1);
        chk("t5_data_kept", 32'(data), 32'h3FF);
        chk("t5_valid", 32'(valid), 0);
        chk("t5_rises", nrise, 0);
        snap();
        send_frame(10'h0AA, 1'b1, DW);
        idle(2);
        grab();
        chk("t5_good", 32'(data), 32'h0AA);
        chk("t5_good_v", 32'(valid), 1);
        chk("t5_ferr2", fe_d, 0);
        ack_mode = 1;
        idle(1);

        // Reset in the middle of the data bits
        send_frame(10'h2A5, 1'b1, 4);
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        chk("t6_data", 32'(data), 0);
        chk("t6_valid", 32'(valid), 0);
        chk("t6_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        ack_mode = 0;
        send_frame(10'h123, 1'b1, DW);
        idle(2);
        chk("t6_next", 32'(data), 32'h123);
        chk("t6_next_v", 32'(valid), 1);

        // Receiver disabled in the middle of the data bits
        send_frame(10'h2A5, 1'b1, 4);
        rx_en = 1'b0;
        @(negedge clk);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_data", 32'(data), 32'h123);
        chk("t7_valid", 32'(valid), 1);
        idle(2);
        rx_en = 1'b1;
        idle(1);
        chk("t7_idle", 32'(busy), 0);
        chk("t7_hold", 32'(data), 32'h123);
        ack_mode = 1;
        idle(1);
        ack_mode = 0;
        snap();
        send_frame(10'h123, 1'b1, DW);
        idle(2);
        grab();
        chk("t7_rises", nrise, 1);
        if (nrise == 1)
            chk("t7_next", 32'(rise_q[0]), 32'h123);

        // Random frames, gaps, stop errors and host behaviour
        for (int n = 0; n < 40; n++) begin
            ack_mode = $urandom_range(0, 2);
            rw = DW'($urandom);
            rstop = ($urandom_range(0, 7) != 0);
            send_frame(rw, rstop, DW);
            if (!rstop) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                idle(2);
            end else begin
                idle($urandom_range(0, 3));
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream stage of the UART transmitter on the same link.
- Frame format: one start bit (0), DATA_W data bits LSB first, one stop bit (1), at least two idle bits (1) between frames.
- Transmitter is paced by a baud strobe on its enable, so each bit lasts CLKS_PER_BIT clocks. This block oversamples at that rate, recovers the word, and presents it to the host with a valid/ack handshake.

Parameters:
- DATA_W, 10, data bits per frame (matches transmitter word width).
- CLKS_PER_BIT, 16, clocks per serial bit; even, >= 4; mid-bit point = CLKS_PER_BIT/2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low.
- rx_en  input  1  receiver enable; low forces IDLE.
- rx  input  1  serial line, asynchronous, idles high.
- data_ack  input  1  host consumed data; clears valid.
- data  output  DATA_W  last good received word.
- valid  output  1  data holds an unread word (level).
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: unread word overwritten.
- busy  output  1  high while in START/DATA/STOP/BREAK.

Behaviour:
- Reset (rst=0 at clk edge):
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Both synchronizer flops = 1; state=IDLE; counters=0.
  - Applies mid-frame; the partial word is discarded.
- Synchronizer: 2-flop on rx, output rx_s. All decisions use rx_s. Previous rx_s is registered for edge detection.
- State machine:
  - IDLE: busy=0. When rx_en=1 and a falling edge is seen on rx_s (prev=1, now=0): go to START, clear the clock counter.
  - START: count to CLKS_PER_BIT/2-1, then sample rx_s.
    - 0: go to DATA, clear the counter and bit index.
    - 1: treat as a glitch and return to IDLE; no flag raised.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into the shift register, shifting right with the new bit entering the MSB. After DATA_W samples, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - 1: load data from the shift register, set valid, go to IDLE.
    - 0: pulse frame_err, leave data and valid unchanged, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A line held low never produces a spurious frame.
- Timing:
  - Every sample is taken at the mid-bit point.
  - valid rises on the cycle after the stop-bit sample.
  - Latency from the detected rx_s falling edge to valid = CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT + 1 clocks, plus 2 clocks of synchronizer delay from rx.
- Handshake:
  - valid stays 1 until data_ack=1 is sampled.
  - data_ack while valid=0 has no effect.
  - Completion and data_ack in the same cycle: new word loaded, valid stays 1, no overrun.
  - Completion while valid=1 and data_ack=0: data overwritten, valid stays 1, overrun pulses 1 cycle.
- rx_en:
  - rx_en=0 in any state: next state IDLE, busy drops next cycle, partial word discarded.
  - data and valid are held; the synchronizer keeps running.
  - A frame already in progress when rx_en rises is ignored until a fresh falling edge.
- Back-to-back frames: IDLE is re-entered after the stop sample, which is mid-stop-bit. The next start edge is therefore detected even with zero idle bits.
- Widths:
  - Clock counter width = clog2(CLKS_PER_BIT).
  - Bit index width = clog2(DATA_W+1).
  - Counters do not wrap within a state; each is cleared on every transition.

Test Plan (CLKS_PER_BIT=16, DATA_W=10; frames driven by the transmitter with its enable strobed every 16 clocks):
- Single frame 10'h2A5 -> data=10'h2A5, valid=1 exactly 16/2+11*16+1=185 clocks after the rx_s falling edge; busy high throughout; frame_err=0, overrun=0.
- Frames 10'h001 then 10'h3FF, data_ack pulsed after each -> two valid episodes with correct data; no overrun.
- Same two frames with no data_ack -> data=10'h3FF, valid=1, overrun pulses once at the second completion.
- rx low for 5 clocks then high -> START returns to IDLE; no valid, no frame_err; busy high for at most 8 clocks.
- Frame 10'h155 with stop bit forced 0, line held low 40 clocks, then a good frame 10'h0AA -> frame_err pulses once, data unchanged (old value), then data=10'h0AA with valid.
- rst=0 or rx_en=0 asserted mid-DATA of 10'h2A5 -> reset case: all outputs go to reset values; rx_en case: busy=0 next cycle and data/valid hold. In both cases the next full frame 10'h123 is received correctly.
